// File: rtl/alu_sweep_checker.sv
// alu_sweep_checker
//   Exhaustive on-chip stimulus/response checker for a 4-bit ALU.
//   On start, every {code, a, b} vector (1024 in total) is driven to the ALU.
//   Each vector is held for SETTLE cycles, and then alu_c is compared against
//   a built-in reference model. Mismatches are counted, and the first failing
//   vector is latched together with the result the ALU actually returned.
//
// Parameters
//   SETTLE     : cycles each vector is held before sampling (1..15)
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle sweep request, accepted in IDLE or DONE
//   alu_code   : registered opcode to the ALU
//   alu_a      : registered operand a to the ALU
//   alu_b      : registered operand b to the ALU
//   alu_c      : ALU result, combinational from alu_code/alu_a/alu_b
//   busy       : sweep in progress
//   done       : sweep finished; held until rst or the next accepted start
//   pass       : done with zero mismatches
//   err_count  : number of mismatching vectors (0..1024)
//   err_valid  : first_err holds a latched mismatch
//   first_err  : {code, a, b, observed c} of the first mismatch
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for start
// WAIT  | vector on the ALU inputs, settle counter running down
// CHECK | sample alu_c, score it, then advance or finish
// DONE  | sweep complete, results and last vector held
module alu_sweep_checker #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [1:0]  alu_code,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [4:0]  alu_c,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count,
    output logic        err_valid,
    output logic [14:0] first_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
    localparam logic [9:0] IDX_LAST    = 10'd1023;

    state_t      state;
    state_t      state_next;
    logic [9:0]  idx;
    logic [3:0]  settle_cnt;
    logic        settle_tc;
    logic        accept;
    logic        last_vec;
    logic [4:0]  expected_c;
    logic        mismatch;

    function automatic logic [4:0] ref_model(input logic [1:0] code,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
        logic [4:0] r;
        case (code)
            2'd0:    r = {1'b0, a} + {1'b0, b};
            2'd1:    r = {1'b0, a} - {1'b0, b};
            2'd2:    r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    // The vector register doubles as the ALU drive: idx is {code, a, b}.
    assign alu_code = idx[9:8];
    assign alu_a    = idx[7:4];
    assign alu_b    = idx[3:0];

    assign expected_c = ref_model(alu_code, alu_a, alu_b);
    assign mismatch   = (alu_c != expected_c);
    assign settle_tc  = (settle_cnt == 4'd1);
    assign last_vec   = (idx == IDX_LAST);
    assign accept     = start && ((state == S_IDLE) || (state == S_DONE));

    assign busy = (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 11'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (settle_tc) state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = last_vec ? S_DONE : S_WAIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 10'd0;
            settle_cnt <= 4'd0;
            err_count  <= 11'd0;
            err_valid  <= 1'b0;
            first_err  <= 15'd0;
        end else if (accept) begin
            idx        <= 10'd0;
            settle_cnt <= SETTLE_LOAD;
            err_count  <= 11'd0;
            err_valid  <= 1'b0;
            first_err  <= 15'd0;
        end else if (state == S_WAIT) begin
            settle_cnt <= settle_cnt - 4'd1;
        end else if (state == S_CHECK) begin
            if (mismatch) begin
                err_count <= err_count + 11'd1;
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    first_err <= {idx, alu_c};
                end
            end
            // The last vector stays on the outputs through DONE.
            if (!last_vec) begin
                idx        <= idx + 10'd1;
                settle_cnt <= SETTLE_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_alu_sweep_checker.sv
module tb_alu_sweep_checker;

    logic        clk;
    logic        rst;
    logic        start1;
    logic        start3;
    int          mode1;
    int          mode3;

    logic [1:0]  code1, code3;
    logic [3:0]  a1, a3, b1, b3;
    logic [4:0]  c1, c3;
    logic        busy1, busy3, done1, done3, pass1, pass3;
    logic [10:0] errc1, errc3;
    logic        errv1, errv3;
    logic [14:0] ferr1, ferr3;

    int total;
    int bad;

    // mode 0: good ALU, 1: output stuck at zero, 2: bit 4 inverted on code 3
    function automatic logic [4:0] alu_fn(input int mode, input logic [1:0] code,
                                          input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (code)
            2'd0:    r = 5'(a) + 5'(b);
            2'd1:    r = 5'(a) - 5'(b);
            2'd2:    r = 5'(a & b);
            default: r = 5'(a | b);
        endcase
        if (mode == 1) r = 5'd0;
        if (mode == 2 && code == 2'd3) r = r ^ 5'b10000;
        return r;
    endfunction

    assign c1 = alu_fn(mode1, code1, a1, b1);
    assign c3 = alu_fn(mode3, code3, a3, b3);

    alu_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .alu_code(code1), .alu_a(a1), .alu_b(b1), .alu_c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(errc1), .err_valid(errv1), .first_err(ferr1)
    );

    alu_sweep_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .alu_code(code3), .alu_a(a3), .alu_b(b3), .alu_c(c3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(errc3), .err_valid(errv3), .first_err(ferr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start on dut1 for one cycle; returns 1 ns after the accept edge.
    task automatic pulse_start1();
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    // Count edges from the accept edge until done1, bounded by limit.
    task automatic wait_done1(input int limit, output int n);
        n = 0;
        while (!done1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if ({code1, a1, b1} !== 10'd0) begin bad++; $display("FAIL reset_vec got=%0d want=0", {code1, a1, b1}); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done1); end
        total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass1); end
        total++; if (errc1 !== 11'd0) begin bad++; $display("FAIL reset_errc got=%0d want=0", errc1); end
        total++; if (errv1 !== 1'b0) begin bad++; $display("FAIL reset_errv got=%b want=0", errv1); end
        total++; if (ferr1 !== 15'd0) begin bad++; $display("FAIL reset_ferr got=%h want=0", ferr1); end
        total++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin bad++; $display("FAIL reset_dut3 got=%b%b want=00", busy3, done3); end
    endtask

    task automatic test_good_sweep();
        int n;
        mode1 = 0;
        pulse_start1();
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL good_busy_start got=%b want=1", busy1); end
        wait_done1(3000, n);
        total++; if (n !== 2048) begin bad++; $display("FAIL good_latency got=%0d want=2048", n); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL good_busy_end got=%b want=0", busy1); end
        total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL good_pass got=%b want=1", pass1); end
        total++; if (errc1 !== 11'd0) begin bad++; $display("FAIL good_errc got=%0d want=0", errc1); end
        total++; if (errv1 !== 1'b0) begin bad++; $display("FAIL good_errv got=%b want=0", errv1); end
        total++; if ({code1, a1, b1} !== 10'h3FF) begin bad++; $display("FAIL good_last_vec got=%h want=3ff", {code1, a1, b1}); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (done1 !== 1'b1 || pass1 !== 1'b1) begin bad++; $display("FAIL good_hold got=%b%b want=11", done1, pass1); end
    endtask

    task automatic test_stuck_zero();
        int n;
        mode1 = 1;
        pulse_start1();
        wait_done1(3000, n);
        total++; if (n !== 2048) begin bad++; $display("FAIL stuck_latency got=%0d want=2048", n); end
        total++; if (errc1 !== 11'd925) begin bad++; $display("FAIL stuck_errc got=%0d want=925", errc1); end
        total++; if (ferr1 !== {2'd0, 4'd0, 4'd1, 5'd0}) begin bad++; $display("FAIL stuck_ferr got=%h want=%h", ferr1, {2'd0, 4'd0, 4'd1, 5'd0}); end
        total++; if (errv1 !== 1'b1) begin bad++; $display("FAIL stuck_errv got=%b want=1", errv1); end
        total++; if (pass1 !== 1'b0 || done1 !== 1'b1) begin bad++; $display("FAIL stuck_pass_done got=%b%b want=01", pass1, done1); end
    endtask

    task automatic test_code3_bit4();
        int n;
        mode1 = 2;
        pulse_start1();
        wait_done1(3000, n);
        total++; if (errc1 !== 11'd256) begin bad++; $display("FAIL c3b4_errc got=%0d want=256", errc1); end
        total++; if (ferr1 !== {2'd3, 4'd0, 4'd0, 5'b10000}) begin bad++; $display("FAIL c3b4_ferr got=%h want=%h", ferr1, {2'd3, 4'd0, 4'd0, 5'b10000}); end
        total++; if (pass1 !== 1'b0) begin bad++; $display("FAIL c3b4_pass got=%b want=0", pass1); end
    endtask

    task automatic test_restart_after_fail();
        int n;
        mode1 = 0;
        pulse_start1();
        total++; if (errc1 !== 11'd0 || errv1 !== 1'b0 || ferr1 !== 15'd0) begin bad++; $display("FAIL restart_clear got=%0d/%b/%h want=0/0/0", errc1, errv1, ferr1); end
        total++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL restart_state got=done%b busy%b want=done0 busy1", done1, busy1); end
        total++; if ({code1, a1, b1} !== 10'd0) begin bad++; $display("FAIL restart_vec got=%h want=0", {code1, a1, b1}); end
        wait_done1(3000, n);
        total++; if (n !== 2048 || pass1 !== 1'b1) begin bad++; $display("FAIL restart_pass got=n%0d pass%b want=n2048 pass1", n, pass1); end
    endtask

    task automatic test_settle3();
        int n;
        mode3 = 0;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 5000) begin
            @(negedge clk);
            start3 = (n == 100);
            @(posedge clk);
            #1;
            n++;
        end
        start3 = 1'b0;
        total++; if (n !== 4096) begin bad++; $display("FAIL settle3_latency got=%0d want=4096", n); end
        total++; if (pass3 !== 1'b1 || errc3 !== 11'd0) begin bad++; $display("FAIL settle3_pass got=pass%b errc%0d want=pass1 errc0", pass3, errc3); end
        total++; if ({code3, a3, b3} !== 10'h3FF) begin bad++; $display("FAIL settle3_last_vec got=%h want=3ff", {code3, a3, b3}); end
    endtask

    task automatic test_mid_reset();
        int n;
        mode1 = 1;
        pulse_start1();
        n = 0;
        while ({code1, a1, b1} !== 10'd500 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if ({code1, a1, b1} !== 10'd500) begin bad++; $display("FAIL midrst_reach got=%0d want=500", {code1, a1, b1}); end
        total++; if (errv1 !== 1'b1 || busy1 !== 1'b1) begin bad++; $display("FAIL midrst_pre got=errv%b busy%b want=errv1 busy1", errv1, busy1); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if ({code1, a1, b1} !== 10'd0) begin bad++; $display("FAIL midrst_vec got=%0d want=0", {code1, a1, b1}); end
        total++; if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b%b want=000", busy1, done1, pass1); end
        total++; if (errc1 !== 11'd0 || errv1 !== 1'b0 || ferr1 !== 15'd0) begin bad++; $display("FAIL midrst_results got=%0d/%b/%h want=0/0/0", errc1, errv1, ferr1); end
        mode1 = 0;
        repeat (4) @(posedge clk);
        pulse_start1();
        total++; if (busy1 !== 1'b1 || {code1, a1, b1} !== 10'd0) begin bad++; $display("FAIL midrst_restart got=busy%b vec%0d want=busy1 vec0", busy1, {code1, a1, b1}); end
        wait_done1(3000, n);
        total++; if (n !== 2048 || errc1 !== 11'd0 || pass1 !== 1'b1) begin bad++; $display("FAIL midrst_sweep got=n%0d errc%0d pass%b want=n2048 errc0 pass1", n, errc1, pass1); end
    endtask

    task automatic test_rst_start_same();
        @(negedge clk);
        rst = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start1 = 1'b0;
        total++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL rst_wins got=busy%b done%b want=busy0 done0", busy1, done1); end
        @(posedge clk);
        #1;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_wins_idle got=busy%b want=busy0", busy1); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode1  = 0;
        mode3  = 0;
        test_reset();
        test_good_sweep();
        test_stuck_zero();
        test_code3_bit4();
        test_restart_after_fail();
        test_settle3();
        test_mid_reset();
        test_rst_start_same();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
